// File: rtl/dm_bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dm_bus_pkg
//  Description : Shared definitions for the data-memory bus responder. Holds
//                the FSM state encoding, the bus response codes, the byte-lane
//                count and the default data returned on a failed read.
//  Revision    : 1.0 - initial release
// ============================================================================
package dm_bus_pkg;

    // FSM state encoding (explicit 3-bit width)
    typedef logic [2:0] dm_state_t;
    localparam dm_state_t c_ST_IDLE    = 3'd0;
    localparam dm_state_t c_ST_RD_ADDR = 3'd1;
    localparam dm_state_t c_ST_RD_DATA = 3'd2;
    localparam dm_state_t c_ST_WR_REQ  = 3'd3;
    localparam dm_state_t c_ST_WR_RESP = 3'd4;
    localparam dm_state_t c_ST_DONE    = 3'd5;

    // Bus response code for a successful transfer
    localparam logic [1:0] c_RESP_OKAY = 2'b00;

    // Byte lanes of the default 32-bit data path
    localparam int c_BYTE_LANES = 4;

    // Value handed to the CPU when a read fails or times out
    localparam logic [31:0] c_ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

endpackage
`default_nettype wire

// File: rtl/dm_bus_responder_timer.sv
`default_nettype none
// ============================================================================
//  Module      : bus_wait_timer
//  Description : Wait-cycle counter for the bus responder. Counts while
//                enabled, returns to zero on clear, and flags the cycle in
//                which the TIMEOUT-th consecutive wait cycle is being spent.
//  Revision    : 1.0 - initial release
//  Ports       : clk        - clock
//                rst        - synchronous active-high reset
//                i_clr      - zero the counter (wins over i_en)
//                i_en       - count this cycle
//                o_expired  - this is the final allowed wait cycle
// ============================================================================
module bus_wait_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam int c_CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(TIMEOUT - 1);

    logic [c_CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Counter starts at zero on entry, so value TIMEOUT-1 marks the
    // TIMEOUT-th cycle spent waiting; the FSM leaves at the end of it.
    assign o_expired = i_en && (r_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/dm_bus_responder.sv
`default_nettype none
// ============================================================================
//  Module      : dm_bus_responder
//  Description : Memory-side end of the CPU data-memory port. Turns each
//                SRAM-style request into a single valid/ready bus read or
//                write, stalls the CPU until it completes, then returns the
//                read data on DM_OUT.
//  Revision    : 1.0 - initial release
//  Ports       : clk, rst                 - clock, synchronous active-high reset
//                DM_CEB/WEB/BWEB/A/IN     - CPU request (active-low enables)
//                DM_OUT                   - read data to CPU
//                dm_stall                 - pipeline freeze
//                ar_*, r_*                - bus read address / data channels
//                aw_*, w_*, b_*           - bus write address / data / response
//                bus_err                  - sticky error flag
// ============================================================================
module dm_bus_responder
    import dm_bus_pkg::*;
#(
    parameter int              ADDR_W   = 32,
    parameter int              DATA_W   = 8 * c_BYTE_LANES,
    parameter int              TIMEOUT  = 255,
    parameter logic [DATA_W-1:0] ERR_DATA = c_ERR_DATA_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    // CPU side
    input  logic                DM_CEB,
    input  logic                DM_WEB,
    input  logic [DATA_W/8-1:0] DM_BWEB,
    input  logic [ADDR_W-1:0]   DM_A,
    input  logic [DATA_W-1:0]   DM_IN,
    output logic [DATA_W-1:0]   DM_OUT,
    output logic                dm_stall,
    // Read channels
    output logic                ar_valid,
    input  logic                ar_ready,
    output logic [ADDR_W-1:0]   ar_addr,
    input  logic                r_valid,
    output logic                r_ready,
    input  logic [DATA_W-1:0]   r_data,
    input  logic [1:0]          r_resp,
    // Write channels
    output logic                aw_valid,
    input  logic                aw_ready,
    output logic [ADDR_W-1:0]   aw_addr,
    output logic                w_valid,
    input  logic                w_ready,
    output logic [DATA_W-1:0]   w_data,
    output logic [DATA_W/8-1:0] w_strb,
    input  logic                b_valid,
    output logic                b_ready,
    input  logic [1:0]          b_resp,
    output logic                bus_err
);

    localparam int c_LANES = DATA_W / 8;

    dm_state_t           r_state;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [c_LANES-1:0]  r_strb;
    logic [DATA_W-1:0]   r_dm_out;
    logic                r_bus_err;
    logic                r_ar_valid;
    logic                r_r_ready;
    logic                r_aw_valid;
    logic                r_w_valid;
    logic                r_b_ready;
    logic                r_aw_done;
    logic                r_w_done;

    logic w_wait;
    logic w_ar_hs;
    logic w_r_hs;
    logic w_aw_hs;
    logic w_w_hs;
    logic w_b_hs;
    logic w_aw_ok;
    logic w_w_ok;
    logic w_timer_clr;
    logic w_expired;

    assign w_wait = (r_state == c_ST_RD_ADDR) || (r_state == c_ST_RD_DATA) ||
                    (r_state == c_ST_WR_REQ)  || (r_state == c_ST_WR_RESP);

    assign w_ar_hs = r_ar_valid && ar_ready;
    assign w_r_hs  = r_r_ready  && r_valid;
    assign w_aw_hs = r_aw_valid && aw_ready;
    assign w_w_hs  = r_w_valid  && w_ready;
    assign w_b_hs  = r_b_ready  && b_valid;

    // A write channel counts as accepted if it completed earlier or completes now
    assign w_aw_ok = r_aw_done || w_aw_hs;
    assign w_w_ok  = r_w_done  || w_w_hs;

    // Clear outside the wait states and on each wait-to-wait transition so
    // every wait state gets its own full TIMEOUT budget.
    assign w_timer_clr = !w_wait ||
                         ((r_state == c_ST_RD_ADDR) && w_ar_hs) ||
                         ((r_state == c_ST_WR_REQ)  && w_aw_ok && w_w_ok);

    bus_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (w_timer_clr),
        .i_en      (w_wait),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_ST_IDLE;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_strb     <= '0;
            r_dm_out   <= '0;
            r_bus_err  <= 1'b0;
            r_ar_valid <= 1'b0;
            r_r_ready  <= 1'b0;
            r_aw_valid <= 1'b0;
            r_w_valid  <= 1'b0;
            r_b_ready  <= 1'b0;
            r_aw_done  <= 1'b0;
            r_w_done   <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (!DM_CEB) begin
                        r_addr  <= DM_A;
                        r_wdata <= DM_IN;
                        r_strb  <= ~DM_BWEB;
                        if (DM_WEB) begin
                            r_ar_valid <= 1'b1;
                            r_state    <= c_ST_RD_ADDR;
                        end else if (DM_BWEB != {c_LANES{1'b1}}) begin
                            r_aw_valid <= 1'b1;
                            r_w_valid  <= 1'b1;
                            r_aw_done  <= 1'b0;
                            r_w_done   <= 1'b0;
                            r_state    <= c_ST_WR_REQ;
                        end else begin
                            // Every lane disabled: nothing to put on the bus
                            r_state <= c_ST_DONE;
                        end
                    end
                end

                c_ST_RD_ADDR: begin
                    if (w_ar_hs) begin
                        r_ar_valid <= 1'b0;
                        r_r_ready  <= 1'b1;
                        r_state    <= c_ST_RD_DATA;
                    end else if (w_expired) begin
                        r_ar_valid <= 1'b0;
                        r_dm_out   <= ERR_DATA;
                        r_bus_err  <= 1'b1;
                        r_state    <= c_ST_DONE;
                    end
                end

                c_ST_RD_DATA: begin
                    if (w_r_hs) begin
                        r_r_ready <= 1'b0;
                        if (r_resp == c_RESP_OKAY) begin
                            r_dm_out <= r_data;
                        end else begin
                            r_dm_out  <= ERR_DATA;
                            r_bus_err <= 1'b1;
                        end
                        r_state <= c_ST_DONE;
                    end else if (w_expired) begin
                        r_r_ready <= 1'b0;
                        r_dm_out  <= ERR_DATA;
                        r_bus_err <= 1'b1;
                        r_state   <= c_ST_DONE;
                    end
                end

                c_ST_WR_REQ: begin
                    if (w_aw_ok && w_w_ok) begin
                        r_aw_valid <= 1'b0;
                        r_w_valid  <= 1'b0;
                        r_b_ready  <= 1'b1;
                        r_state    <= c_ST_WR_RESP;
                    end else if (w_expired) begin
                        r_aw_valid <= 1'b0;
                        r_w_valid  <= 1'b0;
                        r_bus_err  <= 1'b1;
                        r_state    <= c_ST_DONE;
                    end else begin
                        // Channels retire independently, in either order
                        if (w_aw_hs) begin
                            r_aw_valid <= 1'b0;
                            r_aw_done  <= 1'b1;
                        end
                        if (w_w_hs) begin
                            r_w_valid <= 1'b0;
                            r_w_done  <= 1'b1;
                        end
                    end
                end

                c_ST_WR_RESP: begin
                    if (w_b_hs) begin
                        r_b_ready <= 1'b0;
                        if (b_resp != c_RESP_OKAY) begin
                            r_bus_err <= 1'b1;
                        end
                        r_state <= c_ST_DONE;
                    end else if (w_expired) begin
                        r_b_ready <= 1'b0;
                        r_bus_err <= 1'b1;
                        r_state   <= c_ST_DONE;
                    end
                end

                // One unstalled cycle lets the CPU advance; the request still
                // on its pins belongs to the finished access and is ignored.
                c_ST_DONE: begin
                    r_state <= c_ST_IDLE;
                end

                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign dm_stall = w_wait || ((r_state == c_ST_IDLE) && !DM_CEB);

    assign DM_OUT   = r_dm_out;
    assign bus_err  = r_bus_err;
    assign ar_valid = r_ar_valid;
    assign ar_addr  = r_addr;
    assign r_ready  = r_r_ready;
    assign aw_valid = r_aw_valid;
    assign aw_addr  = r_addr;
    assign w_valid  = r_w_valid;
    assign w_data   = r_wdata;
    assign w_strb   = r_strb;
    assign b_ready  = r_b_ready;

endmodule
`default_nettype wire

// File: tb/tb_dm_bus_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dm_bus_responder
//  Description : Directed self-checking bench for dm_bus_responder, built
//                with an 8-cycle wait budget.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dm_bus_responder;

    logic        clk;
    logic        rst;
    logic        DM_CEB;
    logic        DM_WEB;
    logic [3:0]  DM_BWEB;
    logic [31:0] DM_A;
    logic [31:0] DM_IN;
    logic [31:0] DM_OUT;
    logic        dm_stall;
    logic        ar_valid;
    logic        ar_ready;
    logic [31:0] ar_addr;
    logic        r_valid;
    logic        r_ready;
    logic [31:0] r_data;
    logic [1:0]  r_resp;
    logic        aw_valid;
    logic        aw_ready;
    logic [31:0] aw_addr;
    logic        w_valid;
    logic        w_ready;
    logic [31:0] w_data;
    logic [3:0]  w_strb;
    logic        b_valid;
    logic        b_ready;
    logic [1:0]  b_resp;
    logic        bus_err;

    int n_checks;
    int n_fail;

    dm_bus_responder #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .TIMEOUT  (8),
        .ERR_DATA (32'hDEAD_BEEF)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .DM_CEB   (DM_CEB),
        .DM_WEB   (DM_WEB),
        .DM_BWEB  (DM_BWEB),
        .DM_A     (DM_A),
        .DM_IN    (DM_IN),
        .DM_OUT   (DM_OUT),
        .dm_stall (dm_stall),
        .ar_valid (ar_valid),
        .ar_ready (ar_ready),
        .ar_addr  (ar_addr),
        .r_valid  (r_valid),
        .r_ready  (r_ready),
        .r_data   (r_data),
        .r_resp   (r_resp),
        .aw_valid (aw_valid),
        .aw_ready (aw_ready),
        .aw_addr  (aw_addr),
        .w_valid  (w_valid),
        .w_ready  (w_ready),
        .w_data   (w_data),
        .w_strb   (w_strb),
        .b_valid  (b_valid),
        .b_ready  (b_ready),
        .b_resp   (b_resp),
        .bus_err  (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        DM_CEB   = 1'b1;
        DM_WEB   = 1'b1;
        DM_BWEB  = 4'hF;
        DM_A     = '0;
        DM_IN    = '0;
        ar_ready = 1'b0;
        r_valid  = 1'b0;
        r_data   = '0;
        r_resp   = 2'b00;
        aw_ready = 1'b0;
        w_ready  = 1'b0;
        b_valid  = 1'b0;
        b_resp   = 2'b00;
        tick();
        tick();
        rst = 1'b0;
        #1;

        // ---------------- reset state ----------------
        check("rst_ar_valid", 32'(ar_valid), 32'd0);
        check("rst_r_ready",  32'(r_ready),  32'd0);
        check("rst_aw_valid", 32'(aw_valid), 32'd0);
        check("rst_w_valid",  32'(w_valid),  32'd0);
        check("rst_b_ready",  32'(b_ready),  32'd0);
        check("rst_dm_out",   DM_OUT,        32'd0);
        check("rst_bus_err",  32'(bus_err),  32'd0);
        check("rst_stall",    32'(dm_stall), 32'd0);
        check("rst_ar_addr",  ar_addr,       32'd0);

        // ---------------- read, zero-wait bus ----------------
        DM_CEB   = 1'b0;
        DM_WEB   = 1'b1;
        DM_A     = 32'h0000_1004;
        ar_ready = 1'b1;
        #1;
        check("rd_stall_idle", 32'(dm_stall), 32'd1);
        tick();
        check("rd_ar_valid", 32'(ar_valid), 32'd1);
        check("rd_ar_addr",  ar_addr,       32'h0000_1004);
        check("rd_stall_ar", 32'(dm_stall), 32'd1);
        r_valid = 1'b1;
        r_data  = 32'h1234_5678;
        r_resp  = 2'b00;
        tick();
        check("rd_r_ready",      32'(r_ready),  32'd1);
        check("rd_ar_valid_off", 32'(ar_valid), 32'd0);
        check("rd_stall_r",      32'(dm_stall), 32'd1);
        tick();
        check("rd_done_stall", 32'(dm_stall), 32'd0);
        check("rd_done_out",   DM_OUT,        32'h1234_5678);
        check("rd_done_err",   32'(bus_err),  32'd0);
        check("rd_done_rrdy",  32'(r_ready),  32'd0);
        DM_CEB   = 1'b1;
        r_valid  = 1'b0;
        ar_ready = 1'b0;
        tick();
        check("rd_idle_stall", 32'(dm_stall), 32'd0);
        check("rd_idle_arv",   32'(ar_valid), 32'd0);

        // ---------------- byte write, W before AW ----------------
        DM_CEB   = 1'b0;
        DM_WEB   = 1'b0;
        DM_BWEB  = 4'b1101;
        DM_IN    = 32'h0000_AB00;
        DM_A     = 32'h0000_2008;
        w_ready  = 1'b1;
        aw_ready = 1'b0;
        #1;
        check("wr_stall_idle", 32'(dm_stall), 32'd1);
        tick();
        check("wr_aw_valid", 32'(aw_valid), 32'd1);
        check("wr_w_valid",  32'(w_valid),  32'd1);
        check("wr_w_strb",   32'(w_strb),   32'h2);
        check("wr_w_data",   w_data,        32'h0000_AB00);
        check("wr_aw_addr",  aw_addr,       32'h0000_2008);
        tick();
        w_ready = 1'b0;
        check("wr_w_dropped", 32'(w_valid),  32'd0);
        check("wr_aw_held1",  32'(aw_valid), 32'd1);
        check("wr_stall_req", 32'(dm_stall), 32'd1);
        tick();
        check("wr_aw_held2", 32'(aw_valid), 32'd1);
        check("wr_w_still0", 32'(w_valid),  32'd0);
        aw_ready = 1'b1;
        tick();
        aw_ready = 1'b0;
        check("wr_aw_dropped", 32'(aw_valid), 32'd0);
        check("wr_b_ready",    32'(b_ready),  32'd1);
        check("wr_stall_resp", 32'(dm_stall), 32'd1);
        b_valid = 1'b1;
        b_resp  = 2'b00;
        tick();
        b_valid = 1'b0;
        check("wr_done_stall", 32'(dm_stall), 32'd0);
        check("wr_done_bready", 32'(b_ready), 32'd0);
        check("wr_done_out",   DM_OUT,        32'h1234_5678);
        check("wr_done_err",   32'(bus_err),  32'd0);
        DM_CEB = 1'b1;
        tick();

        // ---------------- empty write ----------------
        DM_CEB   = 1'b0;
        DM_WEB   = 1'b0;
        DM_BWEB  = 4'hF;
        aw_ready = 1'b1;
        w_ready  = 1'b1;
        #1;
        check("ew_stall_idle", 32'(dm_stall), 32'd1);
        tick();
        check("ew_done_stall", 32'(dm_stall), 32'd0);
        check("ew_aw_valid",   32'(aw_valid), 32'd0);
        check("ew_w_valid",    32'(w_valid),  32'd0);
        DM_CEB = 1'b1;
        tick();
        check("ew_idle_aw", 32'(aw_valid), 32'd0);
        check("ew_idle_w",  32'(w_valid),  32'd0);
        check("ew_out",     DM_OUT,        32'h1234_5678);
        aw_ready = 1'b0;
        w_ready  = 1'b0;

        // ---------------- error response, then a good read ----------------
        DM_CEB   = 1'b0;
        DM_WEB   = 1'b1;
        DM_BWEB  = 4'hF;
        DM_A     = 32'h0000_3000;
        ar_ready = 1'b1;
        r_valid  = 1'b1;
        r_data   = 32'h1111_2222;
        r_resp   = 2'b10;
        tick();
        tick();
        tick();
        check("er_done_stall", 32'(dm_stall), 32'd0);
        check("er_out",        DM_OUT,        32'hDEAD_BEEF);
        check("er_bus_err",    32'(bus_err),  32'd1);
        DM_CEB = 1'b1;
        tick();
        DM_CEB = 1'b0;
        r_data = 32'hCAFE_F00D;
        r_resp = 2'b00;
        tick();
        tick();
        tick();
        check("er_good_out", DM_OUT,       32'hCAFE_F00D);
        check("er_sticky",   32'(bus_err), 32'd1);
        DM_CEB   = 1'b1;
        ar_ready = 1'b0;
        r_valid  = 1'b0;
        tick();

        // ---------------- timeout on AR ----------------
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("to_pre_err", 32'(bus_err), 32'd0);
        check("to_pre_out", DM_OUT,       32'd0);
        DM_CEB   = 1'b0;
        DM_WEB   = 1'b1;
        DM_A     = 32'h0000_4000;
        ar_ready = 1'b0;
        tick();
        for (int i = 0; i < 8; i++) begin
            check($sformatf("to_ar_valid_%0d", i), 32'(ar_valid), 32'd1);
            check($sformatf("to_stall_%0d", i),    32'(dm_stall), 32'd1);
            tick();
        end
        check("to_ar_valid_off", 32'(ar_valid), 32'd0);
        check("to_done_stall",   32'(dm_stall), 32'd0);
        check("to_out",          DM_OUT,        32'hDEAD_BEEF);
        check("to_bus_err",      32'(bus_err),  32'd1);
        DM_CEB = 1'b1;
        tick();

        // ---------------- reset in RD_DATA ----------------
        DM_CEB   = 1'b0;
        DM_A     = 32'h0000_5000;
        ar_ready = 1'b1;
        r_valid  = 1'b0;
        tick();
        tick();
        ar_ready = 1'b0;
        check("rs_r_ready_pre", 32'(r_ready), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("rs_r_ready",  32'(r_ready),  32'd0);
        check("rs_ar_valid", 32'(ar_valid), 32'd0);
        check("rs_out",      DM_OUT,        32'd0);
        check("rs_bus_err",  32'(bus_err),  32'd0);
        check("rs_stall_ce0", 32'(dm_stall), 32'd1);
        DM_CEB = 1'b1;
        #1;
        check("rs_stall_ce1", 32'(dm_stall), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
